// File: rtl/freq_synth.sv
// Programmable 50% duty square-wave generator.
// Ports: clk, res (sync high), freq_req/load/ready request side; wave, half_period, err outputs.
module freq_synth #(
    parameter logic [31:0] CLK_HZ = 32'd10_000_000
) (
    input  logic        clk,
    input  logic        res,
    input  logic [23:0] freq_req,
    input  logic        load,
    output logic        ready,
    output logic        wave,
    output logic [31:0] half_period,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]  state;
    logic [24:0] div_d;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [5:0]  iter;
    logic [31:0] cnt;

    logic [24:0] d_req;
    logic        illegal;
    logic        accept;
    logic [32:0] trial;
    logic [32:0] d_ext;
    logic        ge;
    logic [31:0] rem_nxt;

    assign d_req   = {freq_req, 1'b0};
    assign illegal = (freq_req == 24'd0) ||
                     ({8'd0, d_req} > {1'b0, CLK_HZ});
    assign ready   = (state != S_DIV);
    assign accept  = load && ready;

    // Trial remainder is 33 bits wide; after a restoring step the
    // remainder is below D (< 2^25), so 32 stored bits suffice.
    assign trial   = {1'b0, rem, quo[31]};
    assign d_ext   = {8'd0, div_d};
    assign ge      = (trial >= d_ext);
    assign rem_nxt = ge ? 32'(trial - d_ext) : trial[31:0];

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= S_IDLE;
            wave        <= 1'b0;
            half_period <= 32'd0;
            err         <= 1'b0;
            cnt         <= 32'd0;
            div_d       <= 25'd0;
            rem         <= 32'd0;
            quo         <= 32'd0;
            iter        <= 6'd0;
        end else begin
            unique case (state)
                S_DIV: begin
                    if (iter == 6'd32) begin
                        state       <= S_RUN;
                        half_period <= quo;
                        cnt         <= 32'd0;
                        wave        <= 1'b0;
                    end else begin
                        rem  <= rem_nxt;
                        quo  <= {quo[30:0], ge};
                        iter <= iter + 6'd1;
                    end
                end
                S_IDLE, S_RUN: begin
                    if (accept) begin
                        if (illegal) begin
                            state       <= S_IDLE;
                            err         <= 1'b1;
                            half_period <= 32'd0;
                            wave        <= 1'b0;
                            cnt         <= 32'd0;
                        end else begin
                            // Wave and counter freeze until RUN re-entry.
                            state <= S_DIV;
                            err   <= 1'b0;
                            div_d <= d_req;
                            rem   <= 32'd0;
                            quo   <= CLK_HZ;
                            iter  <= 6'd0;
                        end
                    end else if (state == S_RUN) begin
                        if (cnt == half_period - 32'd1) begin
                            cnt  <= 32'd0;
                            wave <= ~wave;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end else begin
                        cnt  <= 32'd0;
                        wave <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 32'd0;
                    wave  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_synth.sv
// Directed bench for freq_synth.
// Table of requests with hand-computed Q plus multi-cycle sequences.
module tb_freq_synth;

    logic        clk;
    logic        res;
    logic [23:0] freq_req;
    logic        load;
    logic        ready;
    logic        wave;
    logic [31:0] half_period;
    logic        err;

    int checks = 0;
    int errors = 0;

    freq_synth #(.CLK_HZ(32'd10_000_000)) dut (
        .clk(clk),
        .res(res),
        .freq_req(freq_req),
        .load(load),
        .ready(ready),
        .wave(wave),
        .half_period(half_period),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] f;
        logic        e;
        logic [31:0] q;
        logic        meas;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] f);
        @(negedge clk);
        freq_req = f;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_div(input logic pulse);
        logic bad;
        logic w0;
        bad = 1'b0;
        w0 = wave;
        for (int k = 1; k <= 33; k++) begin
            if (pulse && (k == 3 || k == 10 || k == 31)) begin
                load = 1'b1;
                freq_req = 24'd7;
            end else begin
                load = 1'b0;
            end
            tick();
            if (k < 33 && (ready !== 1'b0 || wave !== w0)) bad = 1'b1;
        end
        load = 1'b0;
        chk("div_busy_frozen", {31'd0, bad}, 32'd0);
        chk("div_done_ready", {31'd0, ready}, 32'd1);
    endtask

    task automatic measure(input int q);
        int c;
        int lim;
        lim = 2 * q + 4;
        c = 0;
        while (wave !== 1'b1 && c <= lim) begin tick(); c++; end
        chk("first_rise", c, q);
        c = 0;
        while (wave === 1'b1 && c <= lim) begin tick(); c++; end
        chk("high_len", c, q);
        c = 0;
        while (wave !== 1'b1 && c <= lim) begin tick(); c++; end
        chk("low_len", c, q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        load = 1'b1;
        freq_req = 24'd1000;
        tick();
        load = 1'b0;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_wave", {31'd0, wave}, 32'd0);
        chk("rst_hp", half_period, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        res = 1'b0;
        tick();
        tick();
        chk("rst_load_dropped", {31'd0, ready}, 32'd1);
        chk("rst_hp_after", half_period, 32'd0);
    endtask

    initial begin
        vecs[0] = '{24'd800,       1'b0, 32'd6250,    1'b1};
        vecs[1] = '{24'd5_000_000, 1'b0, 32'd1,       1'b1};
        vecs[2] = '{24'd3,         1'b0, 32'd1666666, 1'b0};
        vecs[3] = '{24'd7,         1'b0, 32'd714285,  1'b0};
        vecs[4] = '{24'd0,         1'b1, 32'd0,       1'b0};
        vecs[5] = '{24'd5_000_001, 1'b1, 32'd0,       1'b0};
        vecs[6] = '{24'd1000,      1'b0, 32'd5000,    1'b0};
        vecs[7] = '{24'd1,         1'b0, 32'd5000000, 1'b0};
        vecs[8] = '{24'd16777215,  1'b1, 32'd0,       1'b0};
        vecs[9] = '{24'd3_000_000, 1'b0, 32'd1,       1'b1};

        res = 1'b1;
        load = 1'b0;
        freq_req = 24'd0;
        tick();
        tick();
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_wave", {31'd0, wave}, 32'd0);
        chk("reset_hp", half_period, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        res = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].f);
            chk("acc_err", {31'd0, err}, {31'd0, vecs[i].e});
            if (vecs[i].e) begin
                chk("ill_ready", {31'd0, ready}, 32'd1);
                chk("ill_wave", {31'd0, wave}, 32'd0);
                chk("ill_hp", half_period, 32'd0);
                tick();
                tick();
                chk("err_sticky", {31'd0, err}, 32'd1);
            end else begin
                chk("acc_busy", {31'd0, ready}, 32'd0);
                wait_div(1'b0);
                chk("run_hp", half_period, vecs[i].q);
                chk("run_wave0", {31'd0, wave}, 32'd0);
                if (vecs[i].meas) measure(int'(vecs[i].q));
            end
        end

        // Retune 800 -> 1000 with wave high; load pulses mid-divide ignored.
        do_load(24'd800);
        wait_div(1'b0);
        chk("rt_hp0", half_period, 32'd6250);
        measure(6250);
        do_load(24'd1000);
        chk("rt_wave_held", {31'd0, wave}, 32'd1);
        wait_div(1'b1);
        chk("rt_hp1", half_period, 32'd5000);
        chk("rt_wave0", {31'd0, wave}, 32'd0);
        chk("rt_err", {31'd0, err}, 32'd0);
        measure(5000);

        // Reset mid-DIV.
        do_load(24'd1000);
        for (int k = 0; k < 10; k++) tick();
        do_reset();

        // Reset mid-RUN after an error was flagged.
        do_load(24'd0);
        chk("pre_err", {31'd0, err}, 32'd1);
        do_load(24'd5_000_000);
        wait_div(1'b0);
        tick();
        tick();
        chk("pre_rst_hp", half_period, 32'd1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
